// File: rtl/adpcm_main_prod_acc_sat.sv
// adpcm_main_prod_acc_sat
//   Accumulates a frame of signed multiplier products (NTAPS beats, or fewer
//   when in_last closes it early), arithmetic-shifts the sum right by SHIFT,
//   saturates it to OUT_WIDTH and presents it on a valid/ready output.
//   Optional build macro: ADPCM_ACC_ROUND_EN adds 2^(SHIFT-1) before the
//   shift (round half up); undefined gives a truncating (floor) shift.
//
// Handshake semantics (both sides): a transfer happens at a rising clk edge
// when valid & ready & ce are all 1. valid, once raised, is held with its
// payload stable until that transfer. in_ready is combinational from state
// and ce; all other outputs come straight from flops.
module adpcm_main_prod_acc_sat #(
  parameter int NTAPS     = 6,
  parameter int IN_WIDTH  = 64,
  parameter int ACC_WIDTH = 68,
  parameter int SHIFT     = 14,
  parameter int OUT_WIDTH = 32
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         ce,
  input  logic                         in_valid,
  input  logic [IN_WIDTH-1:0]          in_data,
  input  logic                         in_last,
  output logic                         in_ready,
  output logic                         out_valid,
  output logic [OUT_WIDTH-1:0]         out_data,
  output logic                         out_sat,
  output logic [$clog2(NTAPS+1)-1:0]   out_taps,
  input  logic                         out_ready,
  output logic [1:0]                   dbg_state
);

  localparam int CNT_W = $clog2(NTAPS + 1);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_ACC = 2'd1, S_FIN = 2'd2, S_HOLD = 2'd3} state_e;

  // Saturation bounds expressed at the widened (ACC_WIDTH+1) shift width.
  localparam logic signed [ACC_WIDTH:0] SAT_MAX =
    {{(ACC_WIDTH + 2 - OUT_WIDTH){1'b0}}, {(OUT_WIDTH - 1){1'b1}}};
  localparam logic signed [ACC_WIDTH:0] SAT_MIN =
    {{(ACC_WIDTH + 2 - OUT_WIDTH){1'b1}}, {(OUT_WIDTH - 1){1'b0}}};

`ifdef ADPCM_ACC_ROUND_EN
  localparam logic signed [ACC_WIDTH:0] RND =
    (SHIFT == 0) ? '0 : ((ACC_WIDTH + 1)'(1) << ((SHIFT == 0) ? 0 : SHIFT - 1));
`else
  localparam logic signed [ACC_WIDTH:0] RND = '0;
`endif

  state_e                 state_q, state_d;
  logic [ACC_WIDTH-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   out_valid_q, out_valid_d;
  logic [OUT_WIDTH-1:0]   out_data_q, out_data_d;
  logic                   out_sat_q, out_sat_d;
  logic [CNT_W-1:0]       out_taps_q, out_taps_d;

  logic                   accept;
  logic [ACC_WIDTH-1:0]   in_sext;
  logic [CNT_W-1:0]       cnt_inc;
  logic signed [ACC_WIDTH:0] rnd_sum;
  logic signed [ACC_WIDTH:0] sh;
  logic [OUT_WIDTH-1:0]   fin_data;
  logic                   fin_sat;

  assign accept  = in_valid & in_ready;
  assign in_sext = {{(ACC_WIDTH - IN_WIDTH){in_data[IN_WIDTH-1]}}, in_data};
  assign cnt_inc = cnt_q + CNT_W'(1);

  // FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // FSM next-state logic; nothing advances while ce is low.
  always_comb begin
    state_d = state_q;
    if (ce) begin
      case (state_q)
        S_IDLE: if (accept) state_d = (in_last || NTAPS == 1) ? S_FIN : S_ACC;
        S_ACC:  if (accept) state_d = (in_last || cnt_inc == CNT_W'(NTAPS)) ? S_FIN : S_ACC;
        S_FIN:  state_d = S_HOLD;
        S_HOLD: if (out_ready) state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // FSM outputs: input ready only while collecting a frame.
  always_comb begin
    in_ready  = ce & ((state_q == S_IDLE) | (state_q == S_ACC));
    dbg_state = state_q;
  end

  // Final shift/saturate; the rounding add is one bit wider so it never wraps.
  always_comb begin
    rnd_sum  = $signed({acc_q[ACC_WIDTH-1], acc_q}) + RND;
    sh       = rnd_sum >>> SHIFT;
    fin_data = sh[OUT_WIDTH-1:0];
    fin_sat  = 1'b0;
    if (sh > SAT_MAX) begin
      fin_data = {1'b0, {(OUT_WIDTH - 1){1'b1}}};
      fin_sat  = 1'b1;
    end else if (sh < SAT_MIN) begin
      fin_data = {1'b1, {(OUT_WIDTH - 1){1'b0}}};
      fin_sat  = 1'b1;
    end
  end

  // Datapath next values: accumulate, register the result, clear on hand-off.
  always_comb begin
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sat_d   = out_sat_q;
    out_taps_d  = out_taps_q;
    if (ce) begin
      case (state_q)
        S_IDLE: if (accept) begin
          acc_d = in_sext;
          cnt_d = CNT_W'(1);
        end
        S_ACC: if (accept) begin
          acc_d = acc_q + in_sext;
          cnt_d = cnt_inc;
        end
        S_FIN: begin
          out_data_d  = fin_data;
          out_sat_d   = fin_sat;
          out_taps_d  = cnt_q;
          out_valid_d = 1'b1;
        end
        S_HOLD: if (out_ready) begin
          out_valid_d = 1'b0;
          acc_d       = '0;
          cnt_d       = '0;
        end
        default: ;
      endcase
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc_q       <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sat_q   <= 1'b0;
      out_taps_q  <= '0;
    end else begin
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sat_q   <= out_sat_d;
      out_taps_q  <= out_taps_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sat   = out_sat_q;
  assign out_taps  = out_taps_q;

endmodule

// File: tb/tb_adpcm_main_prod_acc_sat.sv
// tb_adpcm_main_prod_acc_sat
//   Directed bench for the product accumulator with a frame-level reference
//   model (sum, shift, saturate) and a per-cycle compare process.
module tb_adpcm_main_prod_acc_sat;

  localparam int NTAPS = 6;
  localparam int IN_W  = 64;
  localparam int ACC_W = 68;
  localparam int SHIFT = 14;
  localparam int OUT_W = 32;
  localparam int CNT_W = $clog2(NTAPS + 1);
  localparam int RES_W = 1 + CNT_W + OUT_W;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic             ce = 1'b1;
  logic             in_valid = 1'b0;
  logic [IN_W-1:0]  in_data = '0;
  logic             in_last = 1'b0;
  logic             in_ready;
  logic             out_valid;
  logic [OUT_W-1:0] out_data;
  logic             out_sat;
  logic [CNT_W-1:0] out_taps;
  logic             out_ready = 1'b1;
  logic [1:0]       dbg_state;

  adpcm_main_prod_acc_sat #(
    .NTAPS(NTAPS), .IN_WIDTH(IN_W), .ACC_WIDTH(ACC_W), .SHIFT(SHIFT), .OUT_WIDTH(OUT_W)
  ) dut (
    .clk(clk), .reset(reset), .ce(ce),
    .in_valid(in_valid), .in_data(in_data), .in_last(in_last), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_sat(out_sat), .out_taps(out_taps),
    .out_ready(out_ready), .dbg_state(dbg_state)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  longint           frame_q[$];
  logic [RES_W-1:0] exp_q[$];
  logic             m_fin = 1'b0;
  logic             m_valid = 1'b0;
  logic [OUT_W-1:0] m_data = '0;
  logic             m_sat = 1'b0;
  logic [CNT_W-1:0] m_taps = '0;

  // Frame result from plain arithmetic: sum, optional round, floor shift, clip.
  function automatic logic [RES_W-1:0] frame_result();
    logic signed [ACC_W+1:0] s;
    logic [OUT_W-1:0] d;
    logic sat;
    longint maxv, minv;
    maxv = (64'sd1 <<< (OUT_W - 1)) - 1;
    minv = -(64'sd1 <<< (OUT_W - 1));
    s = '0;
    foreach (frame_q[i]) s = s + frame_q[i];
`ifdef ADPCM_ACC_ROUND_EN
    if (SHIFT > 0) s = s + (64'sd1 <<< (SHIFT - 1));
`endif
    s = s >>> SHIFT;
    sat = 1'b1;
    if (s > maxv)      d = OUT_W'(maxv);
    else if (s < minv) d = OUT_W'(minv);
    else begin d = s[OUT_W-1:0]; sat = 1'b0; end
    return {sat, CNT_W'(frame_q.size()), d};
  endfunction

  // Model timing: a closed frame is ready one ce-cycle later and held until taken.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      frame_q.delete(); exp_q.delete();
      m_fin = 1'b0; m_valid = 1'b0; m_data = '0; m_sat = 1'b0; m_taps = '0;
    end else if (ce) begin
      if (m_valid) begin
        if (out_ready) m_valid = 1'b0;
      end else if (m_fin) begin
        m_fin = 1'b0;
        m_valid = 1'b1;
        {m_sat, m_taps, m_data} = exp_q.pop_front();
      end else if (in_valid) begin
        frame_q.push_back(longint'(in_data));
        if (in_last || frame_q.size() == NTAPS) begin
          exp_q.push_back(frame_result());
          frame_q.delete();
          m_fin = 1'b1;
        end
      end
    end
  end

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (reset) begin
      chk("in_ready", 64'(in_ready), 64'(ce & ~m_fin & ~m_valid));
      chk("out_valid", 64'(out_valid), 64'(m_valid));
      if (m_valid) begin
        chk("out_data", 64'(out_data), 64'(m_data));
        chk("out_sat", 64'(out_sat), 64'(m_sat));
        chk("out_taps", 64'(out_taps), 64'(m_taps));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_beat(input logic [63:0] d, input logic last);
    int n;
    logic took;
    in_valid = 1'b1; in_data = d; in_last = last;
    took = 1'b0; n = 0;
    while (!took && n < 200) begin
      @(negedge clk);
      took = ce && in_ready;
      @(posedge clk);
      n++;
    end
    #1;
    in_valid = 1'b0; in_last = 1'b0;
    if (!took) begin
      failures++;
      $display("FAIL send_timeout actual=no_accept required=accept t=%0t", $time);
    end
  endtask

  task automatic send_frame(input longint beats[], input int last_idx);
    foreach (beats[i]) send_beat(beats[i], (i == last_idx));
  endtask

  // Wait for a result, then pin both the DUT and the model to literals.
  task automatic wait_result(input string name, input logic [OUT_W-1:0] ed,
                             input logic es, input logic [CNT_W-1:0] et);
    int n;
    n = 0;
    @(negedge clk);
    while (!out_valid && n < 60) begin @(negedge clk); n++; end
    if (!out_valid) begin
      failures++;
      $display("FAIL %s_timeout actual=no_out_valid required=out_valid t=%0t", name, $time);
    end else begin
      chk({name, "_data"}, 64'(out_data), 64'(ed));
      chk({name, "_sat"}, 64'(out_sat), 64'(es));
      chk({name, "_taps"}, 64'(out_taps), 64'(et));
      chk({name, "_model"}, 64'({m_sat, m_taps, m_data}), 64'({es, et, ed}));
    end
    @(posedge clk); #1;
  endtask

  longint t1[] = '{16384, 32768, -16384, 0, 49152, 16384};
  longint tp[] = '{64'sd1 <<< 50, 64'sd1 <<< 50, 64'sd1 <<< 50,
                   64'sd1 <<< 50, 64'sd1 <<< 50, 64'sd1 <<< 50};
  longint tn[] = '{-(64'sd1 <<< 50), -(64'sd1 <<< 50), -(64'sd1 <<< 50),
                   -(64'sd1 <<< 50), -(64'sd1 <<< 50), -(64'sd1 <<< 50)};
  longint te[] = '{100000, -200000};
  logic   toggle_en = 1'b0;

  initial begin
    logic [OUT_W-1:0] held_data;
    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_data", 64'(out_data), 64'd0);
    chk("rst_out_sat", 64'(out_sat), 64'd0);
    chk("rst_out_taps", 64'(out_taps), 64'd0);
    reset = 1'b1;
    @(posedge clk); #1;

    // 1) Nominal frame and two-cycle latency after the 6th beat
    send_frame(t1, -1);
    @(negedge clk); chk("lat_fin", 64'(out_valid), 64'd0);
    @(negedge clk); chk("lat_valid", 64'(out_valid), 64'd1);
    chk("t1_data", 64'(out_data), 64'd6);
    chk("t1_taps", 64'(out_taps), 64'd6);
    @(posedge clk); #1;

    // 2) Saturation, both polarities
    send_frame(tp, -1);
    wait_result("satpos", 32'h7FFF_FFFF, 1'b1, 3'd6);
    send_frame(tn, -1);
    wait_result("satneg", 32'h8000_0000, 1'b1, 3'd6);

    // 3) Early close
    send_frame(te, 1);
`ifdef ADPCM_ACC_ROUND_EN
    wait_result("early", -32'sd6, 1'b0, 3'd2);
`else
    wait_result("early", -32'sd7, 1'b0, 3'd2);
`endif

    // 4) Backpressure with a beat offered during HOLD
    out_ready = 1'b0;
    send_beat(64'(3 * 16384), 1'b0);
    send_beat(64'(16384), 1'b1);
    wait_result("bp", 32'd4, 1'b0, 3'd2);
    held_data = out_data;
    in_valid = 1'b1; in_data = 64'(5 * 16384); in_last = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_hold_valid", 64'(out_valid), 64'd1);
      chk("bp_hold_data", 64'(out_data), 64'(held_data));
      chk("bp_hold_inready", 64'(in_ready), 64'd0);
    end
    @(posedge clk); #1; out_ready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("bp_rel_inready", 64'(in_ready), 64'd1);
    chk("bp_rel_valid", 64'(out_valid), 64'd0);
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
    wait_result("bp_next", 32'd5, 1'b0, 3'd1);

    // 5) ce toggling every cycle during a frame
    toggle_en = 1'b1;
    fork
      begin
        while (toggle_en) begin @(posedge clk); #1; ce = ~ce; end
        ce = 1'b1;
      end
      begin
        send_frame(t1, -1);
        wait_result("ce", 32'd6, 1'b0, 3'd6);
        toggle_en = 1'b0;
      end
    join
    @(posedge clk); #1;

    // 6) Async reset mid-frame, then a fresh frame
    for (int i = 0; i < 3; i++) send_beat(64'(t1[i]), 1'b0);
    #2 reset = 1'b0;
    #1;
    chk("mid_rst_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_data", 64'(out_data), 64'd0);
    chk("mid_rst_sat", 64'(out_sat), 64'd0);
    chk("mid_rst_taps", 64'(out_taps), 64'd0);
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
    send_frame(t1, -1);
    wait_result("post_rst", 32'd6, 1'b0, 3'd6);

    // A few varied frames checked by the model alone
    for (int f = 0; f < 4; f++) begin
      int n;
      n = $urandom_range(NTAPS, 1);
      for (int i = 0; i < n; i++)
        send_beat({$urandom, $urandom} >>> $urandom_range(40, 4), (i == n - 1));
      repeat (4) @(posedge clk);
      #1;
    end

    repeat (5) @(posedge clk);
    chk("exp_q_empty", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
